// File: rtl/mul16_seq.sv
// Iterative 16x16 unsigned shift-add multiplier with a start/done handshake.
// One partial product per cycle is gated through the Hack And16 gate array.

module And16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] out
);
  assign out = a & b;
endmodule

module mul16_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        ready,
  output logic        done,
  output logic [15:0] out,
  output logic [15:0] hi
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] mcand_q, mcand_d;
  logic [31:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] pp;
  logic [16:0] sum;

  And16 u_and16 (
    .a  (mcand_q),
    .b  ({16{acc_q[0]}}),
    .out(pp)
  );

  // Carry out of the running sum lands in acc[31] after the shift.
  assign sum = {1'b0, acc_q[31:16]} + {1'b0, pp};

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a;
          acc_d   = {16'h0000, b};
          cnt_d   = 4'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = {sum, acc_q[15:1]};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      mcand_q <= 16'h0000;
      acc_q   <= 32'h0000_0000;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign done  = (state_q == DONE);
  assign out   = acc_q[15:0];
  assign hi    = acc_q[31:16];
endmodule
